// File: rtl/x_mult_seq.sv
// ---------------------------------------------------------------------------
// x_mult_seq
//   Sequential 32x32 signed multiplier, radix-4 modified Booth recoding.
//   One Booth digit is retired per clock. A product takes 16 RUN cycles,
//   followed by one DONE cycle that carries the ready strobe.
//
// Ports
//   clock           in   sole clock, rising edge
//   reset           in   asynchronous, active-low; forces IDLE and clears state
//   ctrl_MULT       in   start pulse; operands are sampled on the same edge
//   data_operandA   in   [31:0] multiplicand, two's complement
//   data_operandB   in   [31:0] multiplier, two's complement
//   data_result     out  [31:0] low 32 bits of the signed product
//   data_exception  out  product does not fit in 32 bits signed
//   data_resultRDY  out  one-cycle completion strobe (state == DONE)
//   busy            out  high while iterating (state == RUN)
//   dbg_state       out  [1:0] current FSM state, for observation only
//
// Handshake: ctrl_MULT is a single-cycle request that is always accepted,
// including while busy, where it abandons the operation in flight.
// data_resultRDY is a single-cycle strobe with no back-pressure; data_result
// and data_exception stay valid after it until the next accepted start.
// ---------------------------------------------------------------------------
module x_mult_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  count;
  logic [31:0] mcand;

  // Accumulator layout: {34-bit upper [66:33], 32-bit lower [32:1], guard [0]}.
  // The guard bit supplies b(-1) for the first Booth digit. After 16 steps
  // the full signed product sits in [66:1], so its low 64 bits are [64:1].
  logic [66:0] prod;

  logic [33:0] a_ext;
  logic [33:0] a_x2;
  logic [33:0] addend;
  logic [33:0] upper_sum;
  logic [66:0] prod_step;

  // Booth digit selection and one add/shift step.
  always_comb begin
    a_ext  = {{2{mcand[31]}}, mcand};
    a_x2   = {a_ext[32:0], 1'b0};
    addend = '0;
    case (prod[2:0])
      3'b000, 3'b111: addend = '0;
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_x2;
      3'b100:         addend = (~a_x2) + 34'd1;
      3'b101, 3'b110: addend = (~a_ext) + 34'd1;
      default:        addend = '0;
    endcase
    upper_sum = prod[66:33] + addend;
    // Arithmetic shift right by 2 of {upper_sum, prod[32:0]}.
    prod_step = {{2{upper_sum[33]}}, upper_sum, prod[32:2]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= 4'd0;
      mcand <= 32'd0;
      prod  <= 67'd0;
    end else if (ctrl_MULT) begin
      // A start wins in every state, abandoning any operation in flight.
      state <= ST_RUN;
      count <= 4'd0;
      mcand <= data_operandA;
      prod  <= {34'd0, data_operandB, 1'b0};
    end else begin
      case (state)
        ST_RUN: begin
          prod  <= prod_step;
          count <= count + 4'd1;
          if (count == 4'd15) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // prod holds so the result stays readable until the next start.
          state <= ST_IDLE;
        end
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come from registers only; no path from the inputs.
  // Exception: P[63:31] (= prod[64:32]) must be all zeros or all ones.
  assign data_result    = prod[32:1];
  assign data_exception = ~((&prod[64:32]) | ~(|prod[64:32]));
  assign data_resultRDY = (state == ST_DONE);
  assign busy           = (state == ST_RUN);
  assign dbg_state      = state;

endmodule

// File: tb/tb_x_mult_seq.sv
module tb_x_mult_seq;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_fail;

  // {exception, result}
  logic [32:0] exp_q[$];

  x_mult_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: holds a start for one edge, returns one negedge later.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Waits (bounded) for the ready strobe; counts negedges and busy samples.
  task automatic wait_rdy(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (data_resultRDY !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clock);
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    data_operandA = 32'h1234_5678;
    data_operandB = 32'h9abc_def0;
    #1;
    n_cmp++;
    if (data_result !== 32'd0) begin
      n_fail++; $display("FAIL reset_result: got %h want 00000000", data_result);
    end
    n_cmp++;
    if ({data_exception, data_resultRDY, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {data_exception, data_resultRDY, busy});
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({data_resultRDY, busy, dbg_state} !== {2'b00, ST_IDLE}) begin
      n_fail++; $display("FAIL reset_idle_hold: got %b want 0000", {data_resultRDY, busy, dbg_state});
    end
  endtask

  task automatic test_basic;
    int c, bc;
    @(negedge clock);
    start_op(32'd3, 32'd4);
    n_cmp++;
    if (dbg_state !== ST_RUN) begin
      n_fail++; $display("FAIL basic_run_state: got %0d want %0d", dbg_state, ST_RUN);
    end
    wait_rdy(c, bc);
    n_cmp++;
    if (c !== 16) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 16", c);
    end
    n_cmp++;
    if (bc !== 16) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d want 16", bc);
    end
    n_cmp++;
    if ({data_exception, data_result} !== {1'b0, 32'd12}) begin
      n_fail++; $display("FAIL basic_result: got %b/%h want 0/0000000c", data_exception, data_result);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_in_done: got %b want 0", busy);
    end
    @(negedge clock);
    n_cmp++;
    if (data_resultRDY !== 1'b0) begin
      n_fail++; $display("FAIL basic_strobe_width: got %b want 0", data_resultRDY);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (data_result !== 32'd12) begin
      n_fail++; $display("FAIL basic_result_hold: got %h want 0000000c", data_result);
    end
  endtask

  task automatic test_signed_vectors;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vr [4];
    logic        ve [4];
    int c, bc;
    // -7*6, 0x7FFFFFFF*-1, 0x80000000*-1, 0x10000*0x10000
    va[0] = 32'hFFFF_FFF9; vb[0] = 32'd6;         vr[0] = 32'hFFFF_FFD6; ve[0] = 1'b0;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'hFFFF_FFFF; vr[1] = 32'h8000_0001; ve[1] = 1'b0;
    va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF; vr[2] = 32'h8000_0000; ve[2] = 1'b1;
    va[3] = 32'h0001_0000; vb[3] = 32'h0001_0000; vr[3] = 32'h0000_0000; ve[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start_op(va[i], vb[i]);
      wait_rdy(c, bc);
      n_cmp++;
      if (c !== 16) begin
        n_fail++; $display("FAIL vec%0d_latency: got %0d want 16", i, c);
      end
      n_cmp++;
      if (data_result !== vr[i]) begin
        n_fail++; $display("FAIL vec%0d_result: got %h want %h", i, data_result, vr[i]);
      end
      n_cmp++;
      if (data_exception !== ve[i]) begin
        n_fail++; $display("FAIL vec%0d_exception: got %b want %b", i, data_exception, ve[i]);
      end
    end
  endtask

  task automatic test_restart;
    int c, bc, early, late;
    @(negedge clock);
    start_op(32'd5, 32'd5);
    early = 0;
    repeat (7) begin
      if (data_resultRDY === 1'b1) early++;
      @(negedge clock);
    end
    start_op(32'd2, 32'hFFFF_FFFD);
    wait_rdy(c, bc);
    n_cmp++;
    if (early !== 0) begin
      n_fail++; $display("FAIL restart_abandoned_strobe: got %0d want 0", early);
    end
    n_cmp++;
    if (c !== 16) begin
      n_fail++; $display("FAIL restart_latency: got %0d want 16", c);
    end
    n_cmp++;
    if ({data_exception, data_result} !== {1'b0, 32'hFFFF_FFFA}) begin
      n_fail++; $display("FAIL restart_result: got %b/%h want 0/fffffffa", data_exception, data_result);
    end
    late = 0;
    repeat (20) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) late++;
    end
    n_cmp++;
    if (late !== 0) begin
      n_fail++; $display("FAIL restart_extra_strobe: got %0d want 0", late);
    end
  endtask

  task automatic test_reset_mid_run;
    int rdy_seen, busy_seen;
    @(negedge clock);
    start_op(32'd9, 32'd9);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({data_exception, data_result, data_resultRDY, busy, dbg_state} !== {1'b0, 32'd0, 2'b00, ST_IDLE}) begin
      n_fail++; $display("FAIL midreset_outputs: got %b/%h/%b/%b/%0d want 0/00000000/0/0/0",
                         data_exception, data_result, data_resultRDY, busy, dbg_state);
    end
    @(negedge clock);
    reset = 1'b1;
    rdy_seen = 0;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_seen++;
      if (busy === 1'b1) busy_seen++;
    end
    n_cmp++;
    if ({rdy_seen, busy_seen} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL midreset_no_strobe: got rdy=%0d busy=%0d want 0/0", rdy_seen, busy_seen);
    end
    n_cmp++;
    if (data_result !== 32'd0) begin
      n_fail++; $display("FAIL midreset_result: got %h want 00000000", data_result);
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2, bc;
    @(negedge clock);
    start_op(32'd6, 32'd7);
    wait_rdy(c1, bc);
    n_cmp++;
    if ({data_exception, data_result} !== {1'b0, 32'd42}) begin
      n_fail++; $display("FAIL b2b_first_result: got %b/%h want 0/0000002a", data_exception, data_result);
    end
    // Start issued while the first strobe is high (DONE cycle).
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rdy(c2, bc);
    n_cmp++;
    if (c2 + 1 !== 17) begin
      n_fail++; $display("FAIL b2b_strobe_spacing: got %0d want 17", c2 + 1);
    end
    n_cmp++;
    if ({data_exception, data_result} !== {1'b0, 32'd1}) begin
      n_fail++; $display("FAIL b2b_second_result: got %b/%h want 0/00000001", data_exception, data_result);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [63:0] p;
    logic [32:0] exp_v;
    int c, bc;
    @(negedge clock);
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 16 == 3) a = 32'h8000_0000;
      if (i % 16 == 7) b = 32'h7FFF_FFFF;
      if (i % 32 == 11) b = 32'hFFFF_FFFF;
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
      exp_q.push_back({~((p[63:31] == 33'd0) || (p[63:31] == {33{1'b1}})), p[31:0]});
      start_op(a, b);
      wait_rdy(c, bc);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (c !== 16) begin
        n_fail++; $display("FAIL rand%0d_latency: got %0d want 16", i, c);
      end
      n_cmp++;
      if ({data_exception, data_result} !== exp_v) begin
        n_fail++; $display("FAIL rand%0d_product: a=%h b=%h got %b/%h want %b/%h",
                           i, a, b, data_exception, data_result, exp_v[32], exp_v[31:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_signed_vectors();
    test_restart();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
